// File: rtl/axi_addr_fifo.sv
// VALID/READY address-channel FIFO for the AR/AW paths of the crossbar.
// Occupancy comes from a counter, so all DEPTH slots are usable and DEPTH need not be 2^n.
module axi_addr_fifo #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   S_AID,
    input  logic [ADDR_WIDTH-1:0] S_AADDR,
    input  logic [LEN_WIDTH-1:0]  S_ALEN,
    input  logic [SIZE_WIDTH-1:0] S_ASIZE,
    input  logic [1:0]            S_ABURST,
    input  logic                  S_AVALID,
    output logic                  S_AREADY,
    output logic [ID_WIDTH-1:0]   M_AID,
    output logic [ADDR_WIDTH-1:0] M_AADDR,
    output logic [LEN_WIDTH-1:0]  M_ALEN,
    output logic [SIZE_WIDTH-1:0] M_ASIZE,
    output logic [1:0]            M_ABURST,
    output logic                  M_AVALID,
    input  logic                  M_AREADY,
    input  logic                  clear,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;

    // Explicit wrap at DEPTH-1: natural overflow is wrong for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign S_AREADY = ~w_full & ~clear;
    assign M_AVALID = ~w_empty & ~clear;
    assign w_push   = S_AVALID & S_AREADY;
    assign w_pop    = M_AVALID & M_AREADY;

    assign w_wdata  = {S_AID, S_AADDR, S_ALEN, S_ASIZE, S_ABURST};
    assign w_rdata  = r_mem[r_rd_ptr];
    assign {M_AID, M_AADDR, M_ALEN, M_ASIZE, M_ABURST} = w_rdata;

    assign count       = r_cnt;
    assign almost_full = (r_cnt >= CNT_W'(AF_LEVEL));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (clear) begin
            // Storage is left as-is; only the bookkeeping is flushed.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wdata;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_addr_fifo.sv
// Scoreboard bench for axi_addr_fifo: a DEPTH=4 instance for fill/drain/clear/reset
// and a DEPTH=3 instance for non-power-of-two pointer wrap.
module tb_axi_addr_fifo;

    localparam int PW = 49;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    // DEPTH=4 instance
    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_clear, a_af;
    logic [3:0]  a_s_id, a_m_id;
    logic [31:0] a_s_addr, a_m_addr;
    logic [7:0]  a_s_len, a_m_len;
    logic [2:0]  a_s_size, a_m_size;
    logic [1:0]  a_s_burst, a_m_burst;
    logic [2:0]  a_count;

    // DEPTH=3 instance
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_clear, b_af;
    logic [3:0]  b_s_id, b_m_id;
    logic [31:0] b_s_addr, b_m_addr;
    logic [7:0]  b_s_len, b_m_len;
    logic [2:0]  b_s_size, b_m_size;
    logic [1:0]  b_s_burst, b_m_burst;
    logic [1:0]  b_count;

    axi_addr_fifo #(.DEPTH(4)) u_dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AID(a_s_id), .S_AADDR(a_s_addr), .S_ALEN(a_s_len), .S_ASIZE(a_s_size),
        .S_ABURST(a_s_burst), .S_AVALID(a_s_valid), .S_AREADY(a_s_ready),
        .M_AID(a_m_id), .M_AADDR(a_m_addr), .M_ALEN(a_m_len), .M_ASIZE(a_m_size),
        .M_ABURST(a_m_burst), .M_AVALID(a_m_valid), .M_AREADY(a_m_ready),
        .clear(a_clear), .count(a_count), .almost_full(a_af)
    );

    axi_addr_fifo #(.DEPTH(3)) u_dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AID(b_s_id), .S_AADDR(b_s_addr), .S_ALEN(b_s_len), .S_ASIZE(b_s_size),
        .S_ABURST(b_s_burst), .S_AVALID(b_s_valid), .S_AREADY(b_s_ready),
        .M_AID(b_m_id), .M_AADDR(b_m_addr), .M_ALEN(b_m_len), .M_ASIZE(b_m_size),
        .M_ABURST(b_m_burst), .M_AVALID(b_m_valid), .M_AREADY(b_m_ready),
        .clear(b_clear), .count(b_count), .almost_full(b_af)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] a_exp_q[$];
    logic [PW-1:0] b_exp_q[$];
    int a_cnt_m = 0;
    int b_cnt_m = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle on the DEPTH=4 port: drive at negedge, check handshake outputs,
    // update the scoreboard, then check count/almost_full after the edge.
    task automatic step_a(input logic sv, input logic [3:0] id, input logic [31:0] addr,
                          input logic mr, input logic clr);
        logic exp_rdy, exp_vld;
        logic [PW-1:0] exp;
        @(negedge ACLK);
        a_s_valid = sv; a_s_id = id; a_s_addr = addr; a_s_len = addr[9:2];
        a_s_size = id[2:0]; a_s_burst = id[1:0]; a_m_ready = mr; a_clear = clr;
        #1;
        exp_rdy = (a_cnt_m < 4) && !clr;
        exp_vld = (a_cnt_m > 0) && !clr;
        check_eq("a_s_ready", a_s_ready, exp_rdy);
        check_eq("a_m_valid", a_m_valid, exp_vld);
        if (exp_vld) begin
            exp = a_exp_q[0];
            check_eq("a_head", {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, exp);
            if (mr) begin
                void'(a_exp_q.pop_front());
                a_cnt_m--;
            end
        end
        if (sv && exp_rdy) begin
            a_exp_q.push_back({id, addr, addr[9:2], id[2:0], id[1:0]});
            a_cnt_m++;
        end
        if (clr) begin
            a_exp_q.delete();
            a_cnt_m = 0;
        end
        @(posedge ACLK);
        #1;
        check_eq("a_count", a_count, a_cnt_m);
        check_eq("a_almost_full", a_af, a_cnt_m >= 3);
    endtask

    task automatic step_b(input logic sv, input logic [3:0] id, input logic [31:0] addr,
                          input logic mr, output logic acc);
        logic exp_rdy, exp_vld;
        logic [PW-1:0] exp;
        @(negedge ACLK);
        b_s_valid = sv; b_s_id = id; b_s_addr = addr; b_s_len = addr[9:2];
        b_s_size = id[2:0]; b_s_burst = id[1:0]; b_m_ready = mr; b_clear = 1'b0;
        #1;
        exp_rdy = (b_cnt_m < 3);
        exp_vld = (b_cnt_m > 0);
        check_eq("b_s_ready", b_s_ready, exp_rdy);
        check_eq("b_m_valid", b_m_valid, exp_vld);
        if (exp_vld) begin
            exp = b_exp_q[0];
            check_eq("b_head", {b_m_id, b_m_addr, b_m_len, b_m_size, b_m_burst}, exp);
            if (mr) begin
                void'(b_exp_q.pop_front());
                b_cnt_m--;
            end
        end
        acc = sv && exp_rdy;
        if (acc) begin
            b_exp_q.push_back({id, addr, addr[9:2], id[2:0], id[1:0]});
            b_cnt_m++;
        end
        @(posedge ACLK);
        #1;
        check_eq("b_count", b_count, b_cnt_m);
        check_eq("b_almost_full", b_af, b_cnt_m >= 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int sent;
        int cyc;

        // clock/reset
        ARESETn = 1'b0;
        a_s_valid = 0; a_s_id = 0; a_s_addr = 0; a_s_len = 0; a_s_size = 0; a_s_burst = 0;
        a_m_ready = 0; a_clear = 0;
        b_s_valid = 0; b_s_id = 0; b_s_addr = 0; b_s_len = 0; b_s_size = 0; b_s_burst = 0;
        b_m_ready = 0; b_clear = 0;
        repeat (2) @(posedge ACLK);
        #1;
        check_eq("rst_a_m_valid", a_m_valid, 0);
        check_eq("rst_a_s_ready", a_s_ready, 1);
        check_eq("rst_a_count", a_count, 0);
        check_eq("rst_a_af", a_af, 0);
        check_eq("rst_a_payload", {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, 0);
        check_eq("rst_b_m_valid", b_m_valid, 0);
        check_eq("rst_b_s_ready", b_s_ready, 1);
        check_eq("rst_b_count", b_count, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // fill with IDs 1..4, then a held-off 5th request
        for (int k = 1; k <= 4; k++) step_a(1, 4'(k), 32'h1000 + 32'(k * 16), 0, 0);
        check_eq("a_full_count", a_count, 4);
        check_eq("a_full_ready", a_s_ready, 0);
        step_a(1, 4'd5, 32'h1050, 0, 0);

        // drain in order
        for (int k = 0; k < 4; k++) step_a(0, 4'd0, 32'h0, 1, 0);
        check_eq("a_drained_valid", a_m_valid, 0);

        // simultaneous push/pop at count=2
        step_a(1, 4'd1, 32'h2000, 0, 0);
        step_a(1, 4'd2, 32'h2004, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step_a(1, 4'(k + 3), 32'h2008 + 32'(k * 4), 1, 0);
            check_eq("a_pp_count", a_count, 2);
        end

        // full with pop: only the pop happens, push lands next cycle
        step_a(1, 4'd10, 32'h3000, 0, 0);
        step_a(1, 4'd11, 32'h3004, 0, 0);
        step_a(1, 4'd12, 32'h3008, 1, 0);
        check_eq("a_fullpop_count", a_count, 3);
        step_a(1, 4'd12, 32'h3008, 0, 0);
        check_eq("a_fullpop_push", a_count, 4);

        // clear at count=3
        step_a(0, 4'd0, 32'h0, 1, 0);
        step_a(1, 4'd13, 32'h4000, 1, 1);
        check_eq("a_clear_count", a_count, 0);

        // refill 2, then async reset between edges
        step_a(1, 4'd14, 32'h4100, 0, 0);
        step_a(1, 4'd15, 32'h4200, 0, 0);
        #2;
        a_s_valid = 1'b0;
        ARESETn = 1'b0;
        #1;
        check_eq("arst_a_m_valid", a_m_valid, 0);
        check_eq("arst_a_count", a_count, 0);
        check_eq("arst_a_af", a_af, 0);
        check_eq("arst_a_payload", {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, 0);
        a_exp_q.delete();
        a_cnt_m = 0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        step_a(1, 4'd7, 32'h5000, 0, 0);
        step_a(0, 4'd0, 32'h0, 1, 0);

        // DEPTH=3: ten accepted requests through a non-power-of-two ring
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 60) begin
            step_b(1, 4'(sent), 32'h100 + 32'(sent * 4), (cyc >= 3) && (cyc % 3 != 0), acc);
            if (acc) sent++;
            cyc++;
        end
        check_eq("b_sent_all", sent, 10);
        for (int k = 0; k < 4; k++) step_b(0, 4'd0, 32'h0, 1, acc);
        check_eq("b_drained_valid", b_m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_addr_fifo.md
# axi_addr_fifo

Parametrised AXI address-channel buffer used on both the AR and AW paths of the crossbar, between a master-side slave port and the arbiter/decoder stage. It holds outstanding read or write address requests. It replaces push/pop control with VALID/READY handshakes on both sides. All DEPTH entries are usable, and depth does not have to be a power of two. It also reports occupancy and an almost-full flag, and supports a synchronous flush.

## Interface
- ID_WIDTH, 4, transaction ID width
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, burst length width (AXI4; set 4 for AXI3)
- SIZE_WIDTH, 3, burst size width
- DEPTH, 4, number of entries; any integer >= 2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- CNT_W, $clog2(DEPTH+1), derived; width of count

Ports:
- ACLK  in  1  clock; all state updates on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- S_AID / S_AADDR / S_ALEN / S_ASIZE / S_ABURST  in  ID_WIDTH / ADDR_WIDTH / LEN_WIDTH / SIZE_WIDTH / 2  incoming request payload
- S_AVALID  in  1  incoming request valid
- S_AREADY  out  1  FIFO can accept a request
- M_AID / M_AADDR / M_ALEN / M_ASIZE / M_ABURST  out  same widths  head-entry payload
- M_AVALID  out  1  head entry valid
- M_AREADY  in  1  downstream accepts head entry
- clear  in  1  synchronous flush of all entries
- count  out  CNT_W  number of stored entries, 0..DEPTH
- almost_full  out  1  count >= AF_LEVEL

## Operation
- Storage: DEPTH-entry array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter cnt. Pointers are $clog2(DEPTH) bits.
- Full and empty are derived from cnt, not from pointer equality. full = (cnt == DEPTH); empty = (cnt == 0). No slot is wasted.
- Pointer wrap: increment to DEPTH-1, then return to 0 explicitly. No reliance on natural overflow, because DEPTH need not be a power of two.
- push = S_AVALID & S_AREADY: write payload to entry[wr_ptr] and advance wr_ptr.
- pop = M_AVALID & M_AREADY: advance rd_ptr.
- S_AREADY = ~full & ~clear. M_AVALID = ~empty & ~clear. Both are combinational from registered cnt and the clear input.
- Push and pop in the same cycle: both pointers advance and cnt is unchanged. This is legal at any non-full, non-empty occupancy.
- When full, push cannot occur even if pop occurs in the same cycle. There is no write-through on full.
- When empty, there is no combinational bypass. A pushed entry appears on M_* one cycle later.
- M_* payload = entry[rd_ptr] at all times. It is only meaningful while M_AVALID = 1.
- clear = 1: on the next edge, wr_ptr, rd_ptr and cnt all go to 0. No handshake can occur in a clear cycle because both READY and VALID are forced low. Storage contents are not cleared.
- AXI stability: once M_AVALID = 1, the head entry and its payload hold until popped or cleared. Upstream is responsible for S-side stability.
- No ordering or ID reordering: strict FIFO order.

## Timing
- Reset (ARESETn = 0, asynchronous): wr_ptr = rd_ptr = 0, cnt = 0, all storage = 0. The outputs during and after reset are:
  - M_AVALID = 0
  - S_AREADY = 1, provided clear = 0
  - count = 0
  - almost_full = 0
  - M_* payload = 0
- Reset deassertion is synchronised externally. The first push is accepted on the first rising edge with ARESETn = 1.
- Latency: S handshake at edge N gives M_AVALID = 1 and the payload on M_* after edge N. The earliest pop is at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- count and almost_full are registered-derived and update on the same edge as cnt.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Test plan
- Reset then fill: DEPTH=4. Push IDs 1,2,3,4 back-to-back with M_AREADY=0.
  - S_AREADY falls after the 4th handshake and count=4.
  - almost_full rises when count reaches 3.
  - A 5th S_AVALID is held off.
- Drain order: from the full state, assert M_AREADY=1 for 4 cycles.
  - M_AID sequence is 1,2,3,4, then M_AVALID=0 and count=0.
- Non-power-of-two wrap: DEPTH=3. Run 10 push/pop pairs with incrementing ADDR 0x100, 0x104, …
  - Output order is preserved across pointer wrap 2→0.
  - count never exceeds 3.
- Simultaneous push/pop: with count=2, assert both handshakes each cycle for 8 cycles.
  - count stays at 2.
  - Popped ADDRs match pushed ADDRs delayed by 2 entries.
- Full with pop: with count=DEPTH, assert S_AVALID and M_AREADY together.
  - Only the pop occurs and count becomes DEPTH-1.
  - The push is accepted on the following cycle.
- Clear and async reset: with count=3, pulse clear.
  - No handshake occurs in that cycle, and count=0 next edge.
  - Refill with 2 entries, then drop ARESETn between edges: M_AVALID=0 and count=0 before the next edge.
